// File: rtl/uart_frame_parser_if.sv
// Byte-in / frame-out bundle between the UART receiver, the frame parser and the command block.
// Handshake: rx_done is a level strobe; the slave takes rx_data once per rising edge of rx_done and
// answers with one-cycle pulses (pl_valid, frame_ok, frame_err) that carry no backpressure.
interface uart_frame_parser_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       pl_valid;
  logic [7:0] pl_data;
  logic [7:0] pl_index;
  logic [7:0] cmd;
  logic [7:0] len;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [2:0] frame_state;

  modport master (
    output rx_data, rx_done,
    input  pl_valid, pl_data, pl_index, cmd, len, frame_ok, frame_err, err_code, frame_state
  );

  modport slave (
    input  rx_data, rx_done,
    output pl_valid, pl_data, pl_index, cmd, len, frame_ok, frame_err, err_code, frame_state
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Parses HEADER, CMD, LEN, payload, CHK frames from a UART byte stream and reports each frame
// as good or errored; payload bytes are streamed out with their index as they arrive.
module uart_frame_parser #(
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 50000
) (
  input logic           clk,
  input logic           rst,
  uart_frame_parser_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  localparam int            TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [7:0]    MAX_L8  = 8'(MAX_LEN);

  localparam logic [1:0] ERR_CHK = 2'b01;
  localparam logic [1:0] ERR_LEN = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  state_t        state;
  logic          rx_done_q;
  logic          accept;
  logic [7:0]    sum;
  logic [7:0]    idx;
  logic [7:0]    cmd_tmp;
  logic [7:0]    len_tmp;
  logic [TW-1:0] timer;

  logic          pl_valid_r;
  logic [7:0]    pl_data_r;
  logic [7:0]    pl_index_r;
  logic [7:0]    cmd_r;
  logic [7:0]    len_r;
  logic          frame_ok_r;
  logic          frame_err_r;
  logic [1:0]    err_code_r;

  // A held rx_done yields exactly one byte: only its rising edge is taken.
  assign accept = bus.rx_done & ~rx_done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      rx_done_q   <= 1'b0;
      sum         <= 8'h00;
      idx         <= 8'h00;
      cmd_tmp     <= 8'h00;
      len_tmp     <= 8'h00;
      timer       <= '0;
      pl_valid_r  <= 1'b0;
      pl_data_r   <= 8'h00;
      pl_index_r  <= 8'h00;
      cmd_r       <= 8'h00;
      len_r       <= 8'h00;
      frame_ok_r  <= 1'b0;
      frame_err_r <= 1'b0;
      err_code_r  <= 2'b00;
    end else begin
      rx_done_q   <= bus.rx_done;
      pl_valid_r  <= 1'b0;
      frame_ok_r  <= 1'b0;
      frame_err_r <= 1'b0;

      if (accept) begin
        timer <= '0;
        case (state)
          S_IDLE: begin
            if (bus.rx_data == HEADER) state <= S_CMD;
          end
          S_CMD: begin
            cmd_tmp <= bus.rx_data;
            sum     <= bus.rx_data;
            state   <= S_LEN;
          end
          S_LEN: begin
            if (bus.rx_data > MAX_L8) begin
              frame_err_r <= 1'b1;
              err_code_r  <= ERR_LEN;
              state       <= S_IDLE;
            end else begin
              len_tmp <= bus.rx_data;
              sum     <= sum + bus.rx_data;
              idx     <= 8'h00;
              state   <= (bus.rx_data == 8'h00) ? S_CHK : S_DATA;
            end
          end
          S_DATA: begin
            pl_valid_r <= 1'b1;
            pl_data_r  <= bus.rx_data;
            pl_index_r <= idx;
            sum        <= sum + bus.rx_data;
            idx        <= idx + 8'h01;
            if (idx == len_tmp - 8'h01) state <= S_CHK;
          end
          S_CHK: begin
            if (bus.rx_data == sum) begin
              frame_ok_r <= 1'b1;
              cmd_r      <= cmd_tmp;
              len_r      <= len_tmp;
            end else begin
              frame_err_r <= 1'b1;
              err_code_r  <= ERR_CHK;
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (state == S_IDLE) begin
        timer <= '0;
      end else if (timer == T_LAST) begin
        // Inter-byte gap too long: abandon the partial frame.
        timer       <= '0;
        frame_err_r <= 1'b1;
        err_code_r  <= ERR_TMO;
        state       <= S_IDLE;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  assign bus.pl_valid    = pl_valid_r;
  assign bus.pl_data     = pl_data_r;
  assign bus.pl_index    = pl_index_r;
  assign bus.cmd         = cmd_r;
  assign bus.len         = len_r;
  assign bus.frame_ok    = frame_ok_r;
  assign bus.frame_err   = frame_err_r;
  assign bus.err_code    = err_code_r;
  assign bus.frame_state = state;

endmodule
